// File: rtl/rob_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rob_pkg
// Description : Shared sizing constants and entry type for the reorder buffer.
//               Groups the core sizing parameters (ROB_DEPTH, ROB_IDX_W,
//               CDB_WIDTH, PRF_IDX_W, ARCH_IDX_W) and the uop-side entry type
//               rob_entry_t {valid, done, rd_arch, rd_phy}.
// Revision    : 1.0 - initial release
// ============================================================================
package rob_pkg;

    // Core sizing parameters
    localparam int ROB_DEPTH  = 32;
    localparam int ROB_IDX_W  = $clog2(ROB_DEPTH);
    localparam int CDB_WIDTH  = 2;
    localparam int PRF_IDX_W  = 6;
    localparam int ARCH_IDX_W = 5;

    // Per-entry ROB state
    typedef struct packed {
        logic                  valid;
        logic                  done;
        logic [ARCH_IDX_W-1:0] rd_arch;
        logic [PRF_IDX_W-1:0]  rd_phy;
    } rob_entry_t;

endpackage : rob_pkg
`default_nettype wire

// File: rtl/rob_ptr.sv
`default_nettype none
// ============================================================================
// Module      : rob_ptr
// Description : Circular-buffer pointer with a wrap bit above the index.
//               Ports: clk, rst (async, active-low), inc (advance by one),
//               idx (entry index), wrap (lap parity bit).
// Revision    : 1.0 - initial release
// ============================================================================
module rob_ptr #(
    parameter int IDX_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [IDX_W-1:0] idx,
    output logic             wrap
);

    // Natural overflow of the index field carries into the wrap bit.
    logic [IDX_W:0] r_ptr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ptr <= '0;
        end else if (inc) begin
            r_ptr <= r_ptr + 1'b1;
        end
    end

    assign idx  = r_ptr[IDX_W-1:0];
    assign wrap = r_ptr[IDX_W];

endmodule : rob_ptr
`default_nettype wire

// File: rtl/rob.sv
`default_nettype none
// ============================================================================
// Module      : rob
// Description : In-order retirement buffer. Allocates rob_ids at dispatch,
//               marks entries done from CDB broadcasts, retires the oldest
//               completed entry (at most one per cycle).
// Ports       : clk, rst (async, active-low)
//               dispatch_valid/ready, dispatch_rd_arch/rd_phy, dispatch_rob_id
//               cdb_valid[CDB_WIDTH], cdb_rob_id (port k at [5k+4:5k])
//               commit_valid, commit_rob_id, commit_rd_arch, commit_rd_phy
//               occupancy (0..ROB_DEPTH)
// Options     : `define ROB_STALL_STATS_EN adds saturating counters
//               stall_full_cnt and head_wait_cnt (32 bits each).
// Revision    : 1.0 - initial release
// ============================================================================
module rob
    import rob_pkg::*;
(
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          dispatch_valid,
    output logic                          dispatch_ready,
    input  logic [ARCH_IDX_W-1:0]         dispatch_rd_arch,
    input  logic [PRF_IDX_W-1:0]          dispatch_rd_phy,
    output logic [ROB_IDX_W-1:0]          dispatch_rob_id,
    input  logic [CDB_WIDTH-1:0]          cdb_valid,
    input  logic [CDB_WIDTH*ROB_IDX_W-1:0] cdb_rob_id,
    output logic                          commit_valid,
    output logic [ROB_IDX_W-1:0]          commit_rob_id,
    output logic [ARCH_IDX_W-1:0]         commit_rd_arch,
    output logic [PRF_IDX_W-1:0]          commit_rd_phy,
    output logic [ROB_IDX_W:0]            occupancy
`ifdef ROB_STALL_STATS_EN
    ,
    output logic [31:0]                   stall_full_cnt,
    output logic [31:0]                   head_wait_cnt
`endif
);

    rob_entry_t             r_entries [ROB_DEPTH];

    logic [ROB_IDX_W-1:0]   w_head_idx;
    logic                   w_head_wrap;
    logic [ROB_IDX_W-1:0]   w_tail_idx;
    logic                   w_tail_wrap;
    logic                   w_full;
    logic                   w_dispatch_fire;
    logic                   w_commit_fire;
    rob_entry_t             w_head_entry;
    logic [ROB_IDX_W-1:0]   w_cdb_id [CDB_WIDTH];

    // ------------------------------------------------------------------
    // Pointers
    // ------------------------------------------------------------------
    rob_ptr #(.IDX_W(ROB_IDX_W)) u_head_ptr (
        .clk  (clk),
        .rst  (rst),
        .inc  (w_commit_fire),
        .idx  (w_head_idx),
        .wrap (w_head_wrap)
    );

    rob_ptr #(.IDX_W(ROB_IDX_W)) u_tail_ptr (
        .clk  (clk),
        .rst  (rst),
        .inc  (w_dispatch_fire),
        .idx  (w_tail_idx),
        .wrap (w_tail_wrap)
    );

    // Ready depends only on registered pointers: a full ROB that retires
    // this cycle still refuses allocation until the next cycle.
    assign w_full          = (w_head_idx == w_tail_idx) && (w_head_wrap != w_tail_wrap);
    assign dispatch_ready  = !w_full;
    assign dispatch_rob_id = w_tail_idx;
    assign w_dispatch_fire = dispatch_valid && !w_full;
    assign occupancy       = {w_tail_wrap, w_tail_idx} - {w_head_wrap, w_head_idx};

    generate
        for (genvar k = 0; k < CDB_WIDTH; k++) begin : g_cdb_id
            assign w_cdb_id[k] = cdb_rob_id[k*ROB_IDX_W +: ROB_IDX_W];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Commit (head entry, registered-state only)
    // ------------------------------------------------------------------
    assign w_head_entry   = r_entries[w_head_idx];
    assign w_commit_fire  = w_head_entry.valid && w_head_entry.done;
    assign commit_valid   = w_commit_fire;
    assign commit_rob_id  = w_commit_fire ? w_head_idx           : '0;
    assign commit_rd_arch = w_commit_fire ? w_head_entry.rd_arch : '0;
    assign commit_rd_phy  = w_commit_fire ? w_head_entry.rd_phy  : '0;

    // ------------------------------------------------------------------
    // Entry storage. Later assignments take priority: dispatch into the
    // tail overrides any (invalid) CDB hit there, and retirement clears the
    // head even if a CDB port re-marks it done in the same cycle.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < ROB_DEPTH; i++) begin
                r_entries[i] <= '0;
            end
        end else begin
            for (int k = 0; k < CDB_WIDTH; k++) begin
                if (cdb_valid[k] && r_entries[w_cdb_id[k]].valid) begin
                    r_entries[w_cdb_id[k]].done <= 1'b1;
                end
            end
            if (w_dispatch_fire) begin
                r_entries[w_tail_idx] <= '{valid:   1'b1,
                                           done:    1'b0,
                                           rd_arch: dispatch_rd_arch,
                                           rd_phy:  dispatch_rd_phy};
            end
            if (w_commit_fire) begin
                r_entries[w_head_idx].valid <= 1'b0;
                r_entries[w_head_idx].done  <= 1'b0;
            end
        end
    end

    // A broadcast for an unallocated entry indicates an upstream bug.
    generate
        for (genvar k = 0; k < CDB_WIDTH; k++) begin : g_cdb_chk
            a_cdb_hits_live: assert property (@(posedge clk) disable iff (!rst)
                cdb_valid[k] |-> r_entries[w_cdb_id[k]].valid);
        end
    endgenerate

`ifdef ROB_STALL_STATS_EN
    // ------------------------------------------------------------------
    // Saturating stall statistics
    // ------------------------------------------------------------------
    logic [31:0] r_stall_full_cnt;
    logic [31:0] r_head_wait_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_full_cnt <= '0;
            r_head_wait_cnt  <= '0;
        end else begin
            if (dispatch_valid && w_full && !(&r_stall_full_cnt)) begin
                r_stall_full_cnt <= r_stall_full_cnt + 32'd1;
            end
            if (w_head_entry.valid && !w_head_entry.done && !(&r_head_wait_cnt)) begin
                r_head_wait_cnt <= r_head_wait_cnt + 32'd1;
            end
        end
    end

    assign stall_full_cnt = r_stall_full_cnt;
    assign head_wait_cnt  = r_head_wait_cnt;
`endif

endmodule : rob
`default_nettype wire

// File: doc/rob.md
Name: rob

Overview:
- In-order retirement buffer for the out-of-order core.
- Allocates the rob_id that the decode stage attaches to each uop sent to the reservation stations.
- Marks entries complete when a matching CDB broadcast arrives, and retires the oldest completed entry each cycle to the architectural-map/free-list side.
- Acts as the consumer end of the CDB that int_rs produces on fu_cdb_out.

Parameters:
- ROB_DEPTH, 32, number of entries; power of two; index = $clog2(ROB_DEPTH) = 5 bits.
- CDB_WIDTH, 2, number of CDB broadcast ports monitored.
- PRF_IDX_W, 6, physical register index width.
- ARCH_IDX_W, 5, architectural register index width.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset (0 = reset asserted).
- dispatch_valid  input  1  decode presents a uop needing a ROB entry.
- dispatch_ready  output  1  ROB can accept an allocation this cycle.
- dispatch_rd_arch  input  ARCH_IDX_W  destination architectural register.
- dispatch_rd_phy  input  PRF_IDX_W  destination physical register.
- dispatch_rob_id  output  5  id allocated on a handshake; equals tail index.
- cdb_valid  input  CDB_WIDTH  per-port broadcast valid.
- cdb_rob_id  input  CDB_WIDTH*5  per-port completing rob_id; port k occupies bits [5k+4:5k].
- commit_valid  output  1  head entry retires this cycle.
- commit_rob_id  output  5  head index.
- commit_rd_arch  output  ARCH_IDX_W  retiring architectural destination.
- commit_rd_phy  output  PRF_IDX_W  retiring physical destination.
- occupancy  output  6  live entry count, 0..32.

Behaviour:
- Storage: ROB_DEPTH entries of {valid, done, rd_arch, rd_phy}. Head and tail pointers are 6 bits (5-bit index + wrap bit).
- Reset (rst=0, async):
  - head = tail = 0; all valid and done bits = 0.
  - dispatch_ready = 1, dispatch_rob_id = 0, commit_valid = 0, commit_rob_id = 0, commit_rd_arch = 0, commit_rd_phy = 0, occupancy = 0.
  - Reset mid-operation discards all entries immediately. No commit is produced in the reset cycle or the first cycle after release.
- empty = (head == tail). full = (index equal AND wrap bits differ).
- dispatch_ready = !full, from registered state only. There is no same-cycle bypass from commit, so a full ROB that commits this cycle still deasserts ready.
- dispatch_rob_id = tail[4:0], combinational and valid whenever dispatch_ready = 1.
- On dispatch_valid && dispatch_ready:
  - entry[tail] <= {valid=1, done=0, rd_arch, rd_phy}.
  - tail <= tail + 1; wrap 31 -> 0 toggles the wrap bit.
- dispatch_valid while full: no state change; decode must hold the uop stable until ready.
- CDB writeback: for each port k with cdb_valid[k], set entry[cdb_rob_id[k]].done <= 1.
  - Multiple ports naming the same id: idempotent.
  - Write to an entry with valid = 0: ignored, and flagged by an assertion.
- Commit:
  - commit_valid = entry[head].valid && entry[head].done, from registered state. No backpressure: commit always completes.
  - On commit: entry[head].valid <= 0, entry[head].done <= 0, head <= head + 1.
  - commit_rob_id, commit_rd_arch and commit_rd_phy reflect entry[head] whenever commit_valid = 1; they are 0 otherwise.
- Latency: CDB broadcast in cycle N -> commit_valid no earlier than cycle N+1. Commit rate is at most 1 per cycle.
- Simultaneous dispatch and commit: both pointers move and occupancy is unchanged. This holds when neither empty nor full.
- rd_arch = 0 is allocated and committed normally; the consumer ignores the x0 write.
- occupancy = tail - head (6-bit subtraction), registered-state derived.

Optional Feature:
- Macro ROB_STALL_STATS_EN.
- Defined:
  - Adds output stall_full_cnt (32 bits), which counts cycles where dispatch_valid && !dispatch_ready.
  - Adds output head_wait_cnt (32 bits), which counts cycles where the head is valid but not done.
  - Both counters saturate at 32'hFFFF_FFFF and reset to 0 on rst.
- Undefined: neither port nor any counter logic exists; the interface is exactly as listed above.

Decomposition:
- cpu_params: ROB_DEPTH, ROB_IDX_W (5), CDB_WIDTH, PRF_IDX_W, ARCH_IDX_W.
- uop_types: rob_entry_t packed struct {valid, done, rd_arch, rd_phy}.
- Sub-module rob_ptr: wrap-bit pointer (increment enable, index/wrap outputs), instantiated twice for head and tail. Full/empty comparison stays in rob.

Test Plan:
- Reset release -> dispatch_ready=1, occupancy=0, commit_valid=0 for 5 idle cycles.
- Dispatch 3 uops (rd_arch 1/3/5, rd_phy 1/3/5) -> rob_id 0/1/2. CDB port0 completes id 1, then id 0 -> no commit until id 0 is done. Then commit id 0 (arch 1, phy 1) and id 1 (arch 3, phy 3) on consecutive cycles; id 2 stays pending.
- Out-of-order completion on both ports in one cycle (port0 id 2, port1 id 1, head=1) -> ids 1 and 2 commit back-to-back; occupancy returns to 0.
- Fill 32 entries -> dispatch_ready=0, occupancy=32, extra dispatch_valid ignored. Complete id 0 -> commit of id 0, ready=1 the next cycle. The next allocation gets rob_id 0 with the wrap bit toggled.
- Steady state: dispatch and commit in the same cycle with occupancy 10 -> occupancy stays 10 and pointers advance across the 31->0 wrap correctly.
- Assert rst=0 asynchronously mid-clock with 7 entries, 3 of them done -> outputs go to reset values before the next edge; no commit after release.
